// File: rtl/icache_dm.sv
// Read-only direct-mapped instruction cache: combinational hits, single-line refill on miss.
// Define ICACHE_PERF_EN to add saturating hit_cnt/miss_cnt outputs.
module icache_dm #(
    parameter int INDEX_W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         proc_read,
    input  logic         proc_write,
    input  logic [29:0]  proc_addr,
    input  logic [31:0]  proc_wdata,
    output logic [31:0]  proc_rdata,
    output logic         proc_stall,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
`ifdef ICACHE_PERF_EN
    output logic [15:0]  hit_cnt,
    output logic [15:0]  miss_cnt,
`endif
    input  logic         mem_ready
);
    localparam int TAG_W = 28 - INDEX_W;
    localparam int LINES = 2 ** INDEX_W;

    typedef enum logic {S_IDLE = 1'b0, S_FETCH = 1'b1} state_t;

    // Handshake: mem_read stays high from the miss until the cycle mem_ready is sampled high;
    // mem_ready is a one-cycle pulse qualifying mem_rdata and is ignored outside FETCH.
    state_t                  state_q, state_d;
    logic [LINES-1:0]        valid_q, valid_d;
    logic [TAG_W-1:0]        tag_q  [LINES];
    logic [TAG_W-1:0]        tag_d  [LINES];
    logic [3:0][31:0]        data_q [LINES];
    logic [3:0][31:0]        data_d [LINES];
    logic                    mem_read_q, mem_read_d;
    logic [27:0]             mem_addr_q, mem_addr_d;

    logic [INDEX_W-1:0]      idx;
    logic [TAG_W-1:0]        addr_tag;
    logic [INDEX_W-1:0]      fill_idx;
    logic [TAG_W-1:0]        fill_tag;
    logic                    hit;
    logic                    miss_start;
    logic                    unused_ok;

    assign unused_ok = ^{proc_write, proc_wdata};

    always_comb begin
        idx        = proc_addr[INDEX_W+1:2];
        addr_tag   = proc_addr[29:INDEX_W+2];
        fill_idx   = mem_addr_q[INDEX_W-1:0];
        fill_tag   = mem_addr_q[27:INDEX_W];
        hit        = proc_read && valid_q[idx] && (tag_q[idx] == addr_tag) && (state_q == S_IDLE);
        miss_start = proc_read && !hit && (state_q == S_IDLE);

        proc_rdata = hit ? data_q[idx][proc_addr[1:0]] : 32'd0;
        proc_stall = (state_q == S_FETCH) || (proc_read && !hit);

        state_d    = state_q;
        valid_d    = valid_q;
        tag_d      = tag_q;
        data_d     = data_q;
        mem_read_d = mem_read_q;
        mem_addr_d = mem_addr_q;

        case (state_q)
            S_IDLE: begin
                if (miss_start) begin
                    mem_addr_d = proc_addr[29:2];
                    mem_read_d = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: begin
                // The latched line is installed even if the core has moved on.
                if (mem_ready) begin
                    data_d[fill_idx]  = mem_rdata;
                    tag_d[fill_idx]   = fill_tag;
                    valid_d[fill_idx] = 1'b1;
                    mem_read_d        = 1'b0;
                    state_d           = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            valid_q    <= '0;
            mem_read_q <= 1'b0;
            mem_addr_q <= 28'd0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            mem_read_q <= mem_read_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    assign mem_read  = mem_read_q;
    assign mem_addr  = mem_addr_q;
    assign mem_write = 1'b0;
    assign mem_wdata = 128'd0;

`ifdef ICACHE_PERF_EN
    logic [15:0] hit_cnt_q, hit_cnt_d;
    logic [15:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (hit && (hit_cnt_q != 16'hFFFF)) hit_cnt_d = hit_cnt_q + 16'd1;
        if (miss_start && (miss_cnt_q != 16'hFFFF)) miss_cnt_d = miss_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= 16'd0;
            miss_cnt_q <= 16'd0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif
endmodule

// File: tb/tb_icache_dm.sv
// Directed self-checking bench for icache_dm: inputs driven 1ns after posedge, outputs sampled on negedge.
module tb_icache_dm;
  logic         clk;
  logic         rst;
  logic         proc_read;
  logic         proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;
`ifdef ICACHE_PERF_EN
  logic [15:0]  hit_cnt;
  logic [15:0]  miss_cnt;
`endif

  int checks;
  int errors;

  localparam logic [127:0] LINE_A = {32'h4, 32'h3, 32'h2, 32'h1};
  localparam logic [127:0] LINE_B = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
  localparam logic [127:0] LINE_C = {32'hC3, 32'hC2, 32'hC1, 32'hC0};

  icache_dm dut (
    .clk        (clk),
    .rst        (rst),
    .proc_read  (proc_read),
    .proc_write (proc_write),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_rdata (proc_rdata),
    .proc_stall (proc_stall),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
`ifdef ICACHE_PERF_EN
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt),
`endif
    .mem_ready  (mem_ready)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: issue a read that misses, play memory with the given latency, return at the first unstalled cycle
  task automatic do_miss(input logic [29:0] addr, input logic [127:0] line, input int lat,
                         output int stalls, output int first_rd, output logic [27:0] seen_addr,
                         output bit timeout);
    int rd;
    stalls = 0;
    first_rd = -1;
    seen_addr = '0;
    timeout = 1'b1;
    rd = 0;
    @(posedge clk); #1;
    proc_read = 1'b1;
    proc_addr = addr;
    mem_rdata = line;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (!proc_stall) begin
        timeout = 1'b0;
        break;
      end
      stalls++;
      if (mem_read) begin
        if (first_rd < 0) begin
          first_rd = c;
          seen_addr = mem_addr;
        end
        rd++;
        if (rd == lat + 1) mem_ready = 1'b1;
      end
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    proc_read = 1'b0;
    proc_write = 1'b0;
    proc_addr = '0;
    proc_wdata = '0;
    mem_rdata = '0;
    mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_read !== 1'b0 || mem_addr !== 28'd0 || proc_stall !== 1'b0 || proc_rdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: mem_read=%b mem_addr=%h stall=%b rdata=%h, required 0/0/0/0",
               mem_read, mem_addr, proc_stall, proc_rdata);
    end
    checks++;
    if (mem_write !== 1'b0 || mem_wdata !== 128'd0) begin
      errors++;
      $display("FAIL reset_mem_write: mem_write=%b mem_wdata=%h, required 0/0", mem_write, mem_wdata);
    end
    // stray ready in IDLE must be ignored
    @(posedge clk); #1 mem_ready = 1'b1; mem_rdata = LINE_C;
    @(posedge clk); #1 mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_read !== 1'b0 || proc_stall !== 1'b0) begin
      errors++;
      $display("FAIL stray_ready: mem_read=%b stall=%b, required 0/0", mem_read, proc_stall);
    end
`ifdef ICACHE_PERF_EN
    checks++;
    if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0) begin
      errors++;
      $display("FAIL perf_reset: hit_cnt=%0d miss_cnt=%0d, required 0/0", hit_cnt, miss_cnt);
    end
`endif
  endtask

  task automatic test_cold_miss;
    int stalls, first_rd;
    logic [27:0] seen;
    bit to;
    do_miss(30'h0000_0001, LINE_A, 5, stalls, first_rd, seen, to);
    checks++;
    if (to !== 1'b0) begin
      errors++;
      $display("FAIL cold_timeout: stall still high after 100 cycles, required release");
    end
    checks++;
    if (first_rd !== 1 || seen !== 28'h0) begin
      errors++;
      $display("FAIL cold_req: mem_read first at cycle %0d addr %h, required cycle 1 addr 0", first_rd, seen);
    end
    checks++;
    if (stalls !== 7) begin
      errors++;
      $display("FAIL cold_stall_cycles: got %0d, required 7", stalls);
    end
    checks++;
    if (proc_rdata !== 32'h2 || mem_read !== 1'b0) begin
      errors++;
      $display("FAIL cold_data: rdata=%h mem_read=%b, required 2/0", proc_rdata, mem_read);
    end
  endtask

  task automatic test_same_line_hits;
    logic [31:0] exp_w [4];
    exp_w[0] = 32'h1; exp_w[1] = 32'h2; exp_w[2] = 32'h3; exp_w[3] = 32'h4;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1 proc_addr = 30'(i);
      @(negedge clk);
      checks++;
      if (proc_rdata !== exp_w[i] || proc_stall !== 1'b0 || mem_read !== 1'b0) begin
        errors++;
        $display("FAIL hit_word%0d: rdata=%h stall=%b mem_read=%b, required %h/0/0",
                 i, proc_rdata, proc_stall, mem_read, exp_w[i]);
      end
    end
    @(posedge clk); #1 proc_read = 1'b0;
    @(negedge clk);
    checks++;
    if (proc_rdata !== 32'd0 || proc_stall !== 1'b0) begin
      errors++;
      $display("FAIL idle_outputs: rdata=%h stall=%b, required 0/0", proc_rdata, proc_stall);
    end
`ifdef ICACHE_PERF_EN
    checks++;
    if (hit_cnt !== 16'd5 || miss_cnt !== 16'd1) begin
      errors++;
      $display("FAIL perf_counts: hit_cnt=%0d miss_cnt=%0d, required 5/1", hit_cnt, miss_cnt);
    end
`endif
  endtask

  task automatic test_conflict;
    int stalls, first_rd;
    logic [27:0] seen;
    bit to;
    do_miss(30'h20, LINE_B, 2, stalls, first_rd, seen, to);
    checks++;
    if (to !== 1'b0 || seen !== 28'h8 || stalls !== 4 || proc_rdata !== 32'hB0) begin
      errors++;
      $display("FAIL evict_b: timeout=%b addr=%h stalls=%0d rdata=%h, required 0/8/4/b0",
               to, seen, stalls, proc_rdata);
    end
    do_miss(30'h0, LINE_A, 2, stalls, first_rd, seen, to);
    checks++;
    if (to !== 1'b0 || seen !== 28'h0 || stalls !== 4 || proc_rdata !== 32'h1) begin
      errors++;
      $display("FAIL evict_a: timeout=%b addr=%h stalls=%0d rdata=%h, required 0/0/4/1",
               to, seen, stalls, proc_rdata);
    end
  endtask

  task automatic test_write_ignored;
    @(posedge clk); #1;
    proc_read = 1'b0;
    proc_write = 1'b1;
    proc_addr = 30'h2;
    proc_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if (mem_write !== 1'b0 || mem_read !== 1'b0) begin
      errors++;
      $display("FAIL write_mem: mem_write=%b mem_read=%b, required 0/0", mem_write, mem_read);
    end
    @(posedge clk); #1;
    proc_write = 1'b0;
    proc_read = 1'b1;
    @(negedge clk);
    checks++;
    if (proc_rdata !== 32'h3 || proc_stall !== 1'b0) begin
      errors++;
      $display("FAIL write_readback: rdata=%h stall=%b, required 3/0", proc_rdata, proc_stall);
    end
  endtask

  task automatic test_reset_mid_fetch;
    int stalls, first_rd;
    logic [27:0] seen;
    bit to;
    bit got;
    got = 1'b0;
    @(posedge clk); #1 proc_read = 1'b1; proc_addr = 30'h44; mem_rdata = LINE_C;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (mem_read) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (got !== 1'b1) begin
      errors++;
      $display("FAIL midrst_req: mem_read never rose, required 1");
    end
    @(posedge clk); #1 rst = 1'b1; proc_read = 1'b0;
    @(posedge clk); #1 rst = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_read !== 1'b0 || proc_stall !== 1'b0 || mem_addr !== 28'd0) begin
      errors++;
      $display("FAIL midrst_state: mem_read=%b stall=%b mem_addr=%h, required 0/0/0",
               mem_read, proc_stall, mem_addr);
    end
    @(posedge clk); #1 mem_ready = 1'b0;
    do_miss(30'h44, LINE_C, 1, stalls, first_rd, seen, to);
    checks++;
    if (to !== 1'b0 || seen !== 28'h11 || stalls !== 3 || proc_rdata !== 32'hC0) begin
      errors++;
      $display("FAIL midrst_remiss: timeout=%b addr=%h stalls=%0d rdata=%h, required 0/11/3/c0",
               to, seen, stalls, proc_rdata);
    end
    do_miss(30'h1, LINE_A, 1, stalls, first_rd, seen, to);
    checks++;
    if (to !== 1'b0 || stalls !== 3 || proc_rdata !== 32'h2) begin
      errors++;
      $display("FAIL midrst_invalidated: timeout=%b stalls=%0d rdata=%h, required 0/3/2",
               to, stalls, proc_rdata);
    end
    @(posedge clk); #1 proc_read = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset;
    test_cold_miss;
    test_same_line_hits;
    test_conflict;
    test_write_ignored;
    test_reset_mid_fetch;
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Read-only direct-mapped instruction cache between the RISC-V fetch stage and the slow instruction memory (slow_memI) inside CHIP.
- Serves 32-bit instruction words to the core on hits in the same cycle.
- On a miss, stalls the core, fetches one 128-bit line over the mem_read/mem_ready handshake, installs it, then resumes.

Parameters:
- INDEX_W, 3, index bits; line count = 2**INDEX_W (8 lines x 4 words = 128 B).
- TAG_W, 28-INDEX_W, tag width; derived, do not override.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- proc_read  input  1  fetch request.
- proc_write  input  1  ignored; this is a read-only cache.
- proc_addr  input  30  word address: [1:0] word-in-line, [INDEX_W+1:2] index, [29:INDEX_W+2] tag.
- proc_wdata  input  32  ignored.
- proc_rdata  output  32  instruction word; valid when proc_read=1 and proc_stall=0.
- proc_stall  output  1  core must hold proc_addr/proc_read while high.
- mem_read  output  1  line read request, registered.
- mem_write  output  1  constant 0.
- mem_addr  output  28  line address = proc_addr[29:2] of the missing access, registered.
- mem_wdata  output  128  constant 0.
- mem_rdata  input  128  returned line; word k is bits [32k+31:32k].
- mem_ready  input  1  one-cycle pulse; mem_rdata valid in that cycle.

Behaviour:
- Storage: per line a valid bit, TAG_W tag and 128 data bits, held in flops. Valid bits are cleared by rst; data and tag are not reset.
- Hit = proc_read & valid[idx] & (tag[idx] == addr tag) & state==IDLE. All hit logic is combinational.
- Hit: proc_rdata = word proc_addr[1:0] of the line, proc_stall=0, zero-cycle latency.
- Miss: proc_stall=1 in the same cycle, combinationally.
- proc_read=0: proc_stall=0, proc_rdata=0, no state change.
- FSM has two states.
  - IDLE: on a miss, latch proc_addr[29:2] into mem_addr, set mem_read=1 and go to FETCH.
  - FETCH: proc_stall=1 and mem_read held at 1 until mem_ready is sampled high.
  - On mem_ready: write mem_rdata, tag and valid=1 into the latched index; clear mem_read (it is low in the following cycle); return to IDLE.
  - The next cycle re-evaluates proc_addr and hits.
- Miss penalty: total stall cycles = memory latency + 2 (detect cycle, wait cycles, ready cycle, re-lookup hits).
- mem_ready is ignored in IDLE, including a stray ready after a reset.
- If proc_read drops or proc_addr changes during FETCH, the fetch still completes and installs the latched line.
- Replacement: direct-mapped overwrite. There is no dirty state and no write-back.
- rst mid-FETCH: next cycle state=IDLE, mem_read=0, mem_addr=0, all valid=0. The pending memory response is discarded.
- Reset values: proc_stall=0 (combinational; proc_read=0), proc_rdata=0, mem_read=0, mem_addr=0, mem_write=0, mem_wdata=0.

Optional Feature:
- Macro ICACHE_PERF_EN.
- When defined, two output ports are added:
  - hit_cnt[15:0]: increments on each cycle a hit is served, including the post-fill re-lookup.
  - miss_cnt[15:0]: increments on each IDLE->FETCH transition.
  - Both saturate at 16'hFFFF and are cleared by rst.
- When undefined, the ports and counters do not exist and all other behaviour is identical.

Test Plan:
- Cold miss:
  - Stimulus: after rst, proc_read=1, proc_addr=30'h0000_0001; memory ready 5 cycles after mem_read; mem_rdata={32'h4,32'h3,32'h2,32'h1}.
  - Required: mem_addr=28'h0 and mem_read=1 one cycle after the request; proc_stall high for 7 cycles total.
  - Required: proc_rdata=32'h2 with stall=0; mem_read=0 the cycle after ready.
- Same-line hits: proc_addr 0,1,2,3 on consecutive cycles after the fill -> proc_rdata 1,2,3,4, stall=0 on all four, mem_read never asserted.
- Conflict eviction:
  - Stimulus: fill line address 0, then proc_addr=30'h20 (same index 0, tag 1), then proc_addr=0 again.
  - Required: two further misses with mem_addr=28'h8, then 28'h0, and correct data each time.
- Reset mid-fetch: assert rst for 1 cycle while in FETCH, then pulse mem_ready -> mem_read=0, proc_stall=0 with proc_read=0, a repeat of the same address misses again.
- Write ignored: proc_write=1, proc_wdata=32'hDEAD_BEEF on a cached address -> mem_write stays 0, the next read returns the original data.
- PERF (with ICACHE_PERF_EN): the cold miss followed by 4 hits gives miss_cnt=1 and hit_cnt=5 (post-fill re-lookup plus the 4 hits).
